// File: rtl/midi_note_parser.sv
// MIDI byte-stream parser for a monophonic voice: channel filtering, running status,
// note-on/note-off with last-note priority, and All Notes Off (CC 123).
module midi_note_parser #(
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic [6:0] o_note_num,
  output logic [6:0] o_velocity,
  output logic       o_gate,
  output logic       o_note_stb,
  output logic [1:0] o_dbg_state
);

  // Input side is strobe-only: a byte is consumed in every cycle i_rx_valid=1,
  // there is no ready/backpressure and i_rx_data is don't-care while i_rx_valid=0.

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_D1 = 2'd1;
  localparam logic [1:0] ST_WAIT_D2 = 2'd2;

  localparam logic [2:0] RS_NONE     = 3'd0;
  localparam logic [2:0] RS_NOTE_ON  = 3'd1;
  localparam logic [2:0] RS_NOTE_OFF = 3'd2;
  localparam logic [2:0] RS_CC       = 3'd3;
  localparam logic [2:0] RS_IGNORE   = 3'd4;

  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'h7B;

  logic [1:0] r_state;
  logic [2:0] r_rs;
  logic [6:0] r_d1;

  logic       r_p_valid;
  logic [2:0] r_p_type;
  logic [6:0] r_p_d1;
  logic [6:0] r_p_d2;

  logic [6:0] r_note_num;
  logic [6:0] r_velocity;
  logic       r_gate;
  logic       r_note_stb;

  logic       w_is_realtime;
  logic       w_is_syscom;
  logic       w_is_chan;
  logic       w_is_data;
  logic       w_complete;
  logic [2:0] w_chan_type;
  logic       w_exec_on;
  logic       w_exec_off;
  logic       w_exec_ano;

  always_comb begin
    w_is_realtime = i_rx_valid && (i_rx_data[7:3] == 5'b11111);
    w_is_syscom   = i_rx_valid && (i_rx_data[7:3] == 5'b11110);
    w_is_chan     = i_rx_valid && i_rx_data[7] && (i_rx_data[6:4] != 3'b111);
    w_is_data     = i_rx_valid && !i_rx_data[7];
    w_complete    = w_is_data && (r_state == ST_WAIT_D2);
  end

  // Status bytes for other channels, and the types this voice has no use for,
  // still claim running status so their data bytes get swallowed.
  always_comb begin
    w_chan_type = RS_IGNORE;
    if (i_rx_data[3:0] == CHANNEL) begin
      case (i_rx_data[6:4])
        3'b001:  w_chan_type = RS_NOTE_ON;
        3'b000:  w_chan_type = RS_NOTE_OFF;
        3'b011:  w_chan_type = RS_CC;
        default: w_chan_type = RS_IGNORE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_rs    <= RS_NONE;
      r_d1    <= 7'd0;
    end else if (w_is_realtime) begin
      r_state <= r_state;
    end else if (w_is_syscom) begin
      r_state <= ST_IDLE;
      r_rs    <= RS_NONE;
    end else if (w_is_chan) begin
      r_state <= ST_WAIT_D1;
      r_rs    <= w_chan_type;
    end else if (w_is_data) begin
      case (r_state)
        ST_WAIT_D1: begin
          if (r_rs != RS_IGNORE) begin
            r_d1    <= i_rx_data[6:0];
            r_state <= ST_WAIT_D2;
          end
        end
        ST_WAIT_D2: r_state <= ST_WAIT_D1;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  // A completed message is captured here and executed one edge later against the
  // current output state, giving the one-clock latency from last data byte to outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_p_valid <= 1'b0;
      r_p_type  <= RS_NONE;
      r_p_d1    <= 7'd0;
      r_p_d2    <= 7'd0;
    end else begin
      r_p_valid <= w_complete;
      if (w_complete) begin
        r_p_type <= r_rs;
        r_p_d1   <= r_d1;
        r_p_d2   <= i_rx_data[6:0];
      end
    end
  end

  always_comb begin
    w_exec_on  = r_p_valid && (r_p_type == RS_NOTE_ON) && (r_p_d2 != 7'd0);
    w_exec_off = r_p_valid && r_gate && (r_p_d1 == r_note_num) &&
                 ((r_p_type == RS_NOTE_OFF) ||
                  ((r_p_type == RS_NOTE_ON) && (r_p_d2 == 7'd0)));
    w_exec_ano = r_p_valid && r_gate && (r_p_type == RS_CC) &&
                 (r_p_d1 == CC_ALL_NOTES_OFF);
  end

  // Pitch and velocity are kept after release so the envelope tail sounds at the same note.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_note_num <= 7'd0;
      r_velocity <= 7'd0;
      r_gate     <= 1'b0;
      r_note_stb <= 1'b0;
    end else begin
      r_note_stb <= w_exec_on || w_exec_off || w_exec_ano;
      if (w_exec_on) begin
        r_note_num <= r_p_d1;
        r_velocity <= r_p_d2;
        r_gate     <= 1'b1;
      end else if (w_exec_off || w_exec_ano) begin
        r_gate <= 1'b0;
      end
    end
  end

  assign o_note_num  = r_note_num;
  assign o_velocity  = r_velocity;
  assign o_gate      = r_gate;
  assign o_note_stb  = r_note_stb;
  assign o_dbg_state = r_state;

endmodule

// File: doc/midi_note_parser.md
# midi_note_parser

Front end of the synth voice: parses the MIDI byte stream delivered by the UART receiver and produces the monophonic note state (NOTE_NUM, VELOCITY, GATE) that directly drives the NCO's NOTE_NUM input and the envelope stage. Handles channel filtering, running status, note-on with velocity 0 as note-off, and the All Notes Off control change. Priority is last-note; only the sounding note can be released.

## Interface

- CHANNEL, default 0: MIDI channel (0-15) the parser responds to; 4-bit, static.

- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- RX_DATA  in  8  received MIDI byte; valid only while RX_VALID=1.
- RX_VALID  in  1  single-cycle strobe, one per received byte; back-to-back strobes allowed.
- NOTE_NUM  out  7  current or last note number; feeds NCO NOTE_NUM.
- VELOCITY  out  7  velocity of the last accepted note-on.
- GATE  out  1  1 while a note is held.
- NOTE_STB  out  1  one-cycle pulse whenever NOTE_NUM, VELOCITY or GATE is updated.

## Operation

- Byte classes, decoded only when RX_VALID=1:
  - status = RX_DATA[7]=1; data = RX_DATA[7]=0.
  - realtime F8-FF: ignored entirely; no change to state, running status or captured bytes, even mid-message.
  - system common F0-F7: running status := NONE; state := IDLE.
  - channel status 80-EF: running status := message type; state := WAIT_D1.
- Running status type: NONE, NOTE_ON (9n), NOTE_OFF (8n), CC (Bn), IGNORE. IGNORE covers any channel status with n != CHANNEL, plus An, Cn, Dn, En on CHANNEL.
- FSM states:
  - IDLE: data bytes are discarded.
  - WAIT_D1: a data byte is stored in D1. If type is IGNORE, the byte is discarded and the state stays WAIT_D1. Otherwise go to WAIT_D2.
  - WAIT_D2: a data byte completes the message; execute it, then return to WAIT_D1 (running status).
  - A status byte arriving in WAIT_D2 aborts the pending message and is decoded normally.
- Execute rules (D1 = first data byte, D2 = second):
  - NOTE_ON with D2 != 0: NOTE_NUM := D1; VELOCITY := D2; GATE := 1; pulse NOTE_STB. This applies even if GATE was already 1 (legato re-trigger).
  - NOTE_OFF, or NOTE_ON with D2 = 0: if GATE=1 and D1 = NOTE_NUM, then GATE := 0 and pulse NOTE_STB. Otherwise no output change and no pulse.
  - CC with D1 = 123 (7B): if GATE=1, GATE := 0 and pulse NOTE_STB. Other controllers are ignored.
- NOTE_NUM and VELOCITY hold their values after GATE falls, so release continues at the same pitch.
- Reset (asynchronous, any time including mid-message): NOTE_NUM=0, VELOCITY=0, GATE=0, NOTE_STB=0, state IDLE, running status NONE, D1=0.

## Timing

- Outputs are registered. A message completed by the RX_VALID cycle at edge k updates the outputs at edge k+1, and NOTE_STB is high only during the cycle after edge k+1.
- Latency from the last data byte to the outputs is 1 clock.
- One byte is processed per cycle. There is no backpressure: the parser accepts RX_VALID in every cycle.
- NOTE_STB never stays high for two consecutive cycles unless two messages complete on consecutive strobes.
- RX_DATA is ignored whenever RX_VALID=0.

## Test plan

- Reset, then 90 3C 64 -> after the third strobe: NOTE_NUM=0x3C, VELOCITY=0x64, GATE=1, one NOTE_STB pulse. Outputs read 0 before this.
- Running status: 90 3C 64 3E 50 -> second update gives NOTE_NUM=0x3E, VELOCITY=0x50, GATE=1. Then 3E 00 -> GATE=0, NOTE_NUM stays 0x3E, two pulses in total for these two messages.
- Last-note priority: note-on 3C, note-on 40, then 80 3C 00 -> GATE stays 1, NOTE_NUM=0x40, no pulse. Then 80 40 00 -> GATE=0.
- Channel filter (CHANNEL=0): 91 3C 64 -> no output change and no pulse. Then 3C 64 (still running status on ch1) -> ignored.
- Realtime interleave: 90 F8 3C FE 64 -> identical result to 90 3C 64. Also F0 3C 64 -> ignored. Also B0 7B 00 with GATE=1 -> GATE=0 plus pulse.
- Assert RST after 90 3C only -> all outputs 0 immediately (asynchronously). After release, 64 -> ignored because the state is IDLE.
